// File: rtl/fir_axil_ctrl.sv
// fir_axil_ctrl: AXI-Lite control registers for the FIR engine, plus tap-BRAM
// port sharing between the bus (idle) and the datapath (busy).
module fir_axil_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   i_axis_clk,
    input  logic                   i_axis_rst_n,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [pADDR_WIDTH-1:0] i_awaddr,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    input  logic [pDATA_WIDTH-1:0] i_wdata,
    input  logic                   i_arvalid,
    output logic                   o_arready,
    input  logic [pADDR_WIDTH-1:0] i_araddr,
    output logic                   o_rvalid,
    input  logic                   i_rready,
    output logic [pDATA_WIDTH-1:0] o_rdata,
    output logic [3:0]             o_tap_WE,
    output logic                   o_tap_EN,
    output logic [pDATA_WIDTH-1:0] o_tap_Di,
    output logic [pADDR_WIDTH-1:0] o_tap_A,
    input  logic [pDATA_WIDTH-1:0] i_tap_Do,
    input  logic [pADDR_WIDTH-1:0] i_eng_tap_A,
    output logic                   o_ap_start,
    input  logic                   i_eng_done,
    output logic [pDATA_WIDTH-1:0] o_data_length
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] TAP_END   = TAP_BASE + pADDR_WIDTH'(Tape_Num);

    state_t                  r_state;
    logic                    r_awready, r_arready, r_rvalid, r_ap_start, r_ap_done;
    logic                    r_rd_busy, r_rd_tap, r_tap_wait, r_tap_en, r_tap_we;
    logic [pADDR_WIDTH-1:0]  r_raddr, r_tap_a;
    logic [pDATA_WIDTH-1:0]  r_rdata, r_data_length, r_tap_di;

    logic                    w_idle, w_wr_go, w_wr_fire, w_rd_go, w_rd_done;
    logic                    w_wr_tap, w_rd_tap;
    logic [pDATA_WIDTH-1:0]  w_ctrl, w_reg_rd;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END);
    endfunction

    function automatic logic [pADDR_WIDTH-1:0] tap_addr(input logic [pADDR_WIDTH-1:0] a);
        return (a - TAP_BASE) << 2;
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign w_wr_go   = i_awvalid && i_wvalid && !r_awready;
    assign w_wr_fire = r_awready && i_awvalid && i_wvalid;
    // a write decision in the same cycle holds the read off by one cycle
    assign w_rd_go   = i_arvalid && !r_arready && !r_rd_busy && !w_wr_go;
    assign w_rd_done = r_rvalid && i_rready;
    assign w_wr_tap  = w_idle && is_tap(i_awaddr);
    assign w_rd_tap  = w_idle && is_tap(i_araddr);
    assign w_ctrl    = {{(pDATA_WIDTH-3){1'b0}}, w_idle, r_ap_done, r_ap_start};
    assign w_reg_rd  = (r_raddr == ADDR_CTRL) ? w_ctrl :
                       (r_raddr == ADDR_LEN)  ? r_data_length :
                       is_tap(r_raddr)        ? '1 : '0;

    always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
        if (!i_axis_rst_n) begin
            r_state       <= S_IDLE;
            r_awready     <= 1'b0;
            r_arready     <= 1'b0;
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_ap_start    <= 1'b0;
            r_ap_done     <= 1'b0;
            r_rd_busy     <= 1'b0;
            r_rd_tap      <= 1'b0;
            r_tap_wait    <= 1'b0;
            r_tap_en      <= 1'b0;
            r_tap_we      <= 1'b0;
            r_tap_a       <= '0;
            r_tap_di      <= '0;
            r_raddr       <= '0;
            r_data_length <= '0;
        end else begin
            r_awready  <= w_wr_go;
            r_arready  <= w_rd_go;
            r_ap_start <= 1'b0;
            r_tap_we   <= w_wr_go && w_wr_tap;
            r_tap_en   <= (w_wr_go && w_wr_tap) || (w_rd_go && w_rd_tap);
            r_tap_a    <= w_wr_go ? tap_addr(i_awaddr) : tap_addr(i_araddr);
            r_tap_di   <= i_wdata;
            r_tap_wait <= r_arready && r_rd_tap;
            if (w_rd_go) begin
                r_rd_busy <= 1'b1;
                r_raddr   <= i_araddr;
                r_rd_tap  <= w_rd_tap;
            end else if (w_rd_done) begin
                r_rd_busy <= 1'b0;
            end
            if (r_arready && !r_rd_tap) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_reg_rd;
            end else if (r_tap_wait) begin
                r_rvalid <= 1'b1;
                r_rdata  <= i_tap_Do;
            end else if (w_rd_done) begin
                r_rvalid <= 1'b0;
            end
            if (w_rd_done && r_raddr == ADDR_CTRL)
                r_ap_done <= 1'b0;
            if (w_wr_fire && w_idle) begin
                if (i_awaddr == ADDR_LEN)
                    r_data_length <= i_wdata;
                if (i_awaddr == ADDR_CTRL && i_wdata[0]) begin
                    r_state    <= S_BUSY;
                    r_ap_start <= 1'b1;
                    r_ap_done  <= 1'b0;
                end
            end
            if (!w_idle && i_eng_done) begin
                r_state   <= S_IDLE;
                r_ap_done <= 1'b1;
            end
        end
    end

    assign o_awready     = r_awready;
    assign o_wready      = r_awready;
    assign o_arready     = r_arready;
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = r_rdata;
    assign o_ap_start    = r_ap_start;
    assign o_data_length = r_data_length;
    assign o_tap_A       = w_idle ? r_tap_a : i_eng_tap_A;
    assign o_tap_EN      = !w_idle || r_tap_en;
    assign o_tap_WE      = (w_idle && r_tap_we) ? 4'hF : 4'h0;
    assign o_tap_Di      = r_tap_di;
endmodule

// File: tb/tb_fir_axil_ctrl.sv
// tb_fir_axil_ctrl: directed bench for fir_axil_ctrl with a 1-cycle BRAM model
// and a hand-driven engine (eng_done / eng_tap_A).
module tb_fir_axil_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, rready = 0, eng_done = 0;
    logic        awready, wready, arready, rvalid, tap_EN, ap_start;
    logic [11:0] awaddr = 0, araddr = 0, eng_tap_A = 0, tap_A;
    logic [31:0] wdata = 0, rdata, tap_Di, tap_Do, data_length;
    logic [3:0]  tap_WE;
    logic [31:0] mem [0:15];
    int          n_checks = 0, n_err = 0, we_cnt = 0, start_cnt = 0;
    int          we0, lat;
    logic        seen;
    logic [31:0] taps [0:10];

    fir_axil_ctrl dut (
        .i_axis_clk(clk), .i_axis_rst_n(rst_n),
        .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata),
        .o_tap_WE(tap_WE), .o_tap_EN(tap_EN), .o_tap_Di(tap_Di), .o_tap_A(tap_A),
        .i_tap_Do(tap_Do), .i_eng_tap_A(eng_tap_A),
        .o_ap_start(ap_start), .i_eng_done(eng_done), .o_data_length(data_length)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    always @(negedge clk) begin
        if (tap_WE == 4'hF) we_cnt++;
        if (ap_start) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        logic ok = 1'b0;
        awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (awready) begin
                ok = 1'b1;
                chk("wready_with_awready", {31'b0, wready}, 32'd1);
            end
        end
        chk("write_accepted", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input int exp_lat, input string tag);
        logic ok = 1'b0, early = 1'b0;
        int l = 0;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rvalid) early = 1'b1;
            if (arready) ok = 1'b1;
        end
        chk({tag, "_arready"}, {31'b0, ok}, 32'd1);
        chk({tag, "_rvalid_early"}, {31'b0, early}, 32'd0);
        @(posedge clk); #1;
        arvalid = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!rvalid && l < 20);
        chk({tag, "_data"}, rdata, exp);
        if (exp_lat > 0) chk({tag, "_latency"}, l, exp_lat);
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
    endtask

    initial begin
        taps = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ap_start", {31'b0, ap_start}, 32'd0);
        chk("rst_data_length", data_length, 32'd0);
        chk("rst_tap_we", {28'b0, tap_WE}, 32'd0);
        chk("rst_tap_en", {31'b0, tap_EN}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        axi_read(12'h000, 32'h4, 1, "ctrl_after_reset");
        axi_write(12'h010, 32'd600);
        chk("data_length_port", data_length, 32'd600);
        axi_read(12'h010, 32'd600, 1, "len_readback");
        for (int k = 0; k < 11; k++) begin
            we0 = we_cnt;
            axi_write(12'h020 + 12'(k), taps[k]);
            chk("tap_we_one_cycle", we_cnt - we0, 1);
        end
        for (int k = 0; k < 11; k++)
            axi_read(12'h020 + 12'(k), taps[k], 2, "tap_readback");
        axi_read(12'h014, 32'h0, 1, "unmapped_14");
        axi_read(12'h02B, 32'h0, 1, "unmapped_2b");

        we0 = start_cnt;
        axi_write(12'h000, 32'h1);
        repeat (3) @(negedge clk);
        chk("ap_start_pulse", start_cnt - we0, 1);
        axi_read(12'h000, 32'h0, 1, "ctrl_busy");
        axi_read(12'h023, 32'hFFFF_FFFF, 0, "tap_read_busy");
        we0 = we_cnt;
        axi_write(12'h023, 32'h1234);
        axi_write(12'h010, 32'd5);
        chk("busy_tap_write_no_we", we_cnt - we0, 0);
        chk("busy_len_write_dropped", data_length, 32'd600);
        eng_tap_A = 12'h014;
        @(negedge clk);
        chk("busy_tap_a", {20'b0, tap_A}, 32'h014);
        chk("busy_tap_en", {31'b0, tap_EN}, 32'd1);
        chk("busy_tap_we", {28'b0, tap_WE}, 32'd0);
        @(posedge clk); #1;
        eng_done = 1;
        @(posedge clk); #1;
        eng_done = 0;
        axi_read(12'h000, 32'h6, 1, "ctrl_done");
        axi_read(12'h000, 32'h4, 1, "ctrl_done_cleared");
        axi_read(12'h023, 32'd23, 2, "tap3_unchanged");

        // write and read requested together: write first, then the read
        awaddr = 12'h010; wdata = 32'd777; araddr = 12'h010;
        awvalid = 1; wvalid = 1; arvalid = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (awready) seen = 1'b1;
        end
        chk("conc_aw_first", {31'b0, seen}, 32'd1);
        chk("conc_ar_deferred", {31'b0, arready}, 32'd0);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("conc_ar_next", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        chk("conc_rvalid", {31'b0, rvalid}, 32'd1);
        chk("conc_rdata", rdata, 32'd777);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rdata", rdata, 32'd777);
            chk("hold_rvalid", {31'b0, rvalid}, 32'd1);
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        @(negedge clk);
        chk("conc_rvalid_drop", {31'b0, rvalid}, 32'd0);

        @(posedge clk); #1;
        araddr = 12'h021; arvalid = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (arready) seen = 1'b1;
        end
        chk("rst_rd_arready", {31'b0, seen}, 32'd1);
        @(posedge clk); #1;
        arvalid = 0;
        rst_n = 0;
        #1;
        chk("async_rst_len", data_length, 32'd0);
        @(negedge clk);
        chk("rst_pending_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_pending_arready", {31'b0, arready}, 32'd0);
        @(negedge clk);
        chk("rst_pending_rvalid2", {31'b0, rvalid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        axi_read(12'h010, 32'h0, 1, "len_post_reset");
        axi_read(12'h000, 32'h4, 1, "ctrl_post_reset");
        axi_read(12'h021, taps[1], 2, "bram_kept");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
